// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the fifo_reader read-side controller.
package fifo_reader_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF  = 8;
  localparam int SKID_DEPTH     = 2;
  localparam int OCC_WIDTH      = $clog2(SKID_DEPTH + 1);
  localparam int STAT_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer: absorbs the FIFO read latency so bytes already
// requested always have a slot, regardless of downstream back-pressure.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [OCC_WIDTH-1:0]  occ_o
);

  localparam int PTR_W = $clog2(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [OCC_WIDTH-1:0]  count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset too (not just the pointers) because the
      // head entry drives m_data, which must read 0 out of reset.
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + OCC_WIDTH'(push_i) - OCC_WIDTH'(pop_i);
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = count_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains burst_len bytes from a single-clock FIFO onto a valid/ready
// stream. Define FIFO_READER_STATS_EN to build the beat/stall statistics counters.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  buf_empty,
  input  logic [DATA_WIDTH-1:0] buf_out,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [STAT_WIDTH-1:0] beat_count,
  output logic [STAT_WIDTH-1:0] stall_count
);

  state_e               state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] issued_q;
  logic [LEN_WIDTH-1:0] issued_d;
  logic [LEN_WIDTH-1:0] delivered_q;
  logic [LEN_WIDTH-1:0] delivered_d;
  logic                 inflight_q;
  logic                 pop;
  logic                 credit_ok;
  logic [OCC_WIDTH-1:0] occ;

  // The byte requested last cycle is on buf_out now and lands in the skid.
  fifo_reader_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst),
    .push_i     (inflight_q),
    .push_data_i(buf_out),
    .pop_i      (pop),
    .head_o     (m_data),
    .occ_o      (occ)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave one unassigned and infer a latch.
    pop         = 1'b0;
    credit_ok   = 1'b0;
    rd_en       = 1'b0;
    issued_d    = issued_q;
    delivered_d = delivered_q;

    pop = m_valid && m_ready;
    // A beat leaving this cycle frees its slot in time for a new request,
    // which keeps a full-rate stream at one byte per cycle.
    credit_ok = (int'(occ) + int'(inflight_q) - int'(pop)) < SKID_DEPTH;
    rd_en     = (state_q == ST_FETCH) && !buf_empty && (issued_q < len_q) && credit_ok;

    issued_d    = issued_q + LEN_WIDTH'(rd_en);
    delivered_d = delivered_q + LEN_WIDTH'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values no matter the evaluation order.
      inflight_q <= rd_en;
      unique case (state_q)
        ST_IDLE: begin
          if (start && (burst_len != '0)) begin
            len_q       <= burst_len;
            issued_q    <= '0;
            delivered_q <= '0;
            state_q     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          issued_q    <= issued_d;
          delivered_q <= delivered_d;
          if (issued_d == len_q) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          delivered_q <= delivered_d;
          if (delivered_d == len_q) state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_valid = (occ != '0);
  assign m_last  = m_valid && (delivered_q == len_q - LEN_WIDTH'(1));
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

`ifdef FIFO_READER_STATS_EN
  logic [STAT_WIDTH-1:0] beat_q;
  logic [STAT_WIDTH-1:0] stall_q;

  // Cumulative across bursts; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (pop)                 beat_q  <= sat_inc(beat_q);
      if (m_valid && !m_ready) stall_q <= sat_inc(stall_q);
    end
  end

  assign beat_count  = beat_q;
  assign stall_count = stall_q;
`else
  assign beat_count  = '0;
  assign stall_count = '0;
`endif

endmodule
